fm_modulation: RTL and testbench
================================

Name: fm_modulation

Overview:
Transmit-side counterpart of the FM demodulator. Accepts 14-bit unsigned audio samples, zero-order-holds them at a fixed DAC update rate, and frequency-modulates a numerically controlled oscillator (24-bit phase accumulator plus quarter-wave sine ROM). Drives 12-bit offset-binary I/Q words to the transmit DAC path, with a one-cycle valid strobe per update.

Parameters:
SAMPLE_DIV, 50, clk cycles per DAC update tick (50 MHz clk -> 1 MHz); legal range 4..65535
CARRIER_FCW, 24'h400000, carrier frequency control word (fs/4 by default)
DEV_SHIFT, 4, left shift applied to the signed audio sample to form the deviation word; legal range 0..9

Ports:
clk  input  1  system clock (50 MHz)
RSTn  input  1  asynchronous active-low reset
mod_en  input  1  modulator enable
audio_sample  input  14  unsigned audio, midpoint 14'h2000
audio_valid  input  1  audio_sample is valid this cycle
audio_ready  output  1  input buffer empty; a sample is accepted when audio_valid && audio_ready
I_out  output  12  cosine, offset binary (midpoint 12'h800)
Q_out  output  12  sine, offset binary
out_valid  output  1  one-cycle pulse when I_out/Q_out update

Behaviour:
- Reset values: I_out=Q_out=12'h800, out_valid=0, audio_ready=0, phase_acc=0, tick counter=0, held sample=0, input buffer empty. All pipeline registers clear. Reset may assert at any cycle and takes effect immediately.
- Tick counter: runs only while mod_en=1, counting 0..SAMPLE_DIV-1. tick=1 in the cycle where the count equals SAMPLE_DIV-1; the counter then wraps to 0. The first tick occurs SAMPLE_DIV cycles after mod_en rises.
- Input buffer (one entry): audio_ready = mod_en && buffer empty.
  - On audio_valid && audio_ready, the buffer stores audio_sample with its MSB inverted (signed conversion: 14'h2000 -> 0).
  - On tick with the buffer full, the held sample takes the buffer value and the buffer empties.
  - A write in the same cycle as a tick goes into the buffer and is used at the next tick.
  - With no new sample, the held value repeats.
- Phase update, on tick only: phase_acc <= phase_acc + CARRIER_FCW + sext24(held_sample) <<< DEV_SHIFT, modulo 2^24 (wrap-around allowed, no saturation). The held_sample used is the value before that tick's transfer.
- Pipeline: tick in cycle T -> phase_acc registered at end of T.
  - End of T+1: register q=phase_acc[23:22] and a=phase_acc[21:14].
  - End of T+2: register ROM reads L[a] and L[~a] (two read ports or two ROM copies).
  - End of T+3: register I_out/Q_out and set out_valid=1 for exactly one cycle.
- ROM: L[k] = round(2047*sin(pi/2*(k+0.5)/256)), k=0..255, 11-bit unsigned; L[0]=6, L[255]=2047.
- Quadrant mapping (signed, before adding 2048):
  - q0: sin=+L[a], cos=+L[~a]
  - q1: sin=+L[~a], cos=-L[a]
  - q2: sin=-L[a], cos=-L[~a]
  - q3: sin=-L[~a], cos=+L[a]
  - Q_out = 2048 + sin, I_out = 2048 + cos; output range 1..4095, never overflows.
- mod_en=0:
  - Tick counter cleared, audio_ready=0, phase_acc held, buffer contents held.
  - Ticks already in the pipeline are dropped: out_valid forced 0.
  - I_out/Q_out forced to 12'h800 on the next edge.
  - Re-enable resumes from the held phase.

Test Plan:
- Reset with SAMPLE_DIV=4, inputs idle -> I_out=Q_out=12'h800, out_valid=0, audio_ready=0; asserting RSTn low mid-stream returns the same values immediately.
- mod_en=1, no audio written (held=0), FCW=24'h400000 -> phase 400000/800000/C00000/000000 on successive ticks; first out_valid 3 cycles after the first tick's phase update with Q_out=4095, I_out=2042; next Q_out=2042, I_out=1.
- Write 14'h3FFF -> audio_ready falls the cycle after acceptance and rises after the next tick; the following tick advances phase by 24'h41FFF0.
- Write 14'h0000 -> phase step 24'h3E0000; write 14'h2000 -> step 24'h400000.
- audio_valid coincident with a tick while the buffer is empty -> that tick uses the old held value; the new sample applies on the next tick. Phase starting at 24'hFFFFF0 with step 24'h400000 wraps to 24'h3FFFF0.
- Drop mod_en for 10 cycles mid-pipeline -> no out_valid, outputs 12'h800, phase unchanged; on re-enable, the first tick comes SAMPLE_DIV cycles later and continues from the held phase.

Source files
------------

// File: rtl/fm_modulation.sv
// FM transmit modulator: zero-order-holds 14-bit audio at the DAC update rate and
// steers a 24-bit NCO whose quarter-wave sine lookup drives 12-bit offset-binary I/Q.
module fm_modulation #(
    parameter int unsigned SAMPLE_DIV  = 50,
    parameter logic [23:0] CARRIER_FCW = 24'h400000,
    parameter int unsigned DEV_SHIFT   = 4
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        mod_en,
    input  logic [13:0] audio_sample,
    input  logic        audio_valid,
    output logic        audio_ready,
    output logic [11:0] I_out,
    output logic [11:0] Q_out,
    output logic        out_valid
);

    // Quarter-wave table L[k] = round(2047*sin(pi/2*(k+0.5)/256)), built with Q30 Taylor series.
    function automatic logic [2815:0] build_lut();
        logic [2815:0] lut;
        longint        x;
        longint        term;
        longint        acc;
        lut = '0;
        for (int k = 0; k < 256; k++) begin
            x    = (64'sd3373259426 * longint'(2 * k + 1)) / 64'sd1024;
            term = x;
            acc  = x;
            for (int n = 1; n < 8; n++) begin
                term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            lut[k * 11 +: 11] = 11'((acc * 64'sd2047 + 64'sd536870912) >>> 30);
        end
        return lut;
    endfunction

    localparam logic [2815:0] SINE_LUT_C  = build_lut();
    localparam logic [15:0]   TICK_LAST_C = 16'(SAMPLE_DIV - 1);

    function automatic logic [10:0] lut_rd(input logic [7:0] k);
        logic [11:0] idx;
        idx = 12'(k) * 12'd11;
        return SINE_LUT_C[idx +: 11];
    endfunction

    logic [15:0] tick_cnt_r;
    logic        tick_s;
    logic        accept_s;
    logic        buf_full_r;
    logic [13:0] buf_r;
    logic [13:0] held_r;
    logic [23:0] dev_s;
    logic [23:0] phase_acc_r;
    logic        tick_d_r;
    logic        v1_r;
    logic        v2_r;
    logic [1:0]  q1_r;
    logic [1:0]  q2_r;
    logic [7:0]  a_r;
    logic [10:0] rom_a_r;
    logic [10:0] rom_na_r;
    logic [11:0] i_nxt_s;
    logic [11:0] q_nxt_s;

    assign tick_s      = mod_en && (tick_cnt_r == TICK_LAST_C);
    assign audio_ready = mod_en && !buf_full_r;
    assign accept_s    = audio_valid && audio_ready;
    assign dev_s       = {{10{held_r[13]}}, held_r} << DEV_SHIFT;

    // Update-rate divider; idles at zero while the modulator is disabled.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tick_cnt_r <= 16'd0;
        end else if (!mod_en || tick_s) begin
            tick_cnt_r <= 16'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end

    // One-entry input buffer feeding the held sample; MSB flip makes it two's complement.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            buf_full_r <= 1'b0;
            buf_r      <= 14'd0;
            held_r     <= 14'd0;
        end else if (accept_s) begin
            buf_r      <= audio_sample ^ 14'h2000;
            buf_full_r <= 1'b1;
        end else if (tick_s && buf_full_r) begin
            held_r     <= buf_r;
            buf_full_r <= 1'b0;
        end
    end

    // NCO phase advances once per tick using the sample held before this tick's transfer.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            phase_acc_r <= 24'd0;
        end else if (tick_s) begin
            phase_acc_r <= phase_acc_r + CARRIER_FCW + dev_s;
        end
    end

    // Valid tokens for the lookup pipeline; disabling the modulator drops them all.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tick_d_r <= 1'b0;
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
        end else if (!mod_en) begin
            tick_d_r <= 1'b0;
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
        end else begin
            tick_d_r <= tick_s;
            v1_r     <= tick_d_r;
            v2_r     <= v1_r;
        end
    end

    // Quadrant/address split followed by the dual-port table read of L[a] and L[~a].
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            q1_r     <= 2'd0;
            a_r      <= 8'd0;
            q2_r     <= 2'd0;
            rom_a_r  <= 11'd0;
            rom_na_r <= 11'd0;
        end else begin
            q1_r     <= phase_acc_r[23:22];
            a_r      <= phase_acc_r[21:14];
            q2_r     <= q1_r;
            rom_a_r  <= lut_rd(a_r);
            rom_na_r <= lut_rd(~a_r);
        end
    end

    // Quadrant folding straight into offset binary around 12'h800.
    always_comb begin
        i_nxt_s = 12'h800;
        q_nxt_s = 12'h800;
        case (q2_r)
            2'd0: begin
                q_nxt_s = 12'h800 + {1'b0, rom_a_r};
                i_nxt_s = 12'h800 + {1'b0, rom_na_r};
            end
            2'd1: begin
                q_nxt_s = 12'h800 + {1'b0, rom_na_r};
                i_nxt_s = 12'h800 - {1'b0, rom_a_r};
            end
            2'd2: begin
                q_nxt_s = 12'h800 - {1'b0, rom_a_r};
                i_nxt_s = 12'h800 - {1'b0, rom_na_r};
            end
            2'd3: begin
                q_nxt_s = 12'h800 - {1'b0, rom_na_r};
                i_nxt_s = 12'h800 + {1'b0, rom_a_r};
            end
            default: begin
                q_nxt_s = 12'h800;
                i_nxt_s = 12'h800;
            end
        endcase
    end

    // Output register: midscale while disabled, otherwise hold between updates.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            I_out     <= 12'h800;
            Q_out     <= 12'h800;
            out_valid <= 1'b0;
        end else if (!mod_en) begin
            I_out     <= 12'h800;
            Q_out     <= 12'h800;
            out_valid <= 1'b0;
        end else if (v2_r) begin
            I_out     <= i_nxt_s;
            Q_out     <= q_nxt_s;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_modulation.sv
// Bench for fm_modulation: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the hold buffer, NCO phase and sine lookup.
module tb_fm_modulation;

    localparam int DIV   = 4;
    localparam int FCW   = 32'h0040_0000;
    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        mod_en;
    logic [13:0] audio_sample;
    logic        audio_valid;
    logic        audio_ready;
    logic [11:0] I_out;
    logic [11:0] Q_out;
    logic        out_valid;

    always #5 clk = ~clk;

    fm_modulation #(
        .SAMPLE_DIV (DIV),
        .CARRIER_FCW(24'h400000),
        .DEV_SHIFT  (SHIFT)
    ) dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .mod_en      (mod_en),
        .audio_sample(audio_sample),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .I_out       (I_out),
        .Q_out       (Q_out),
        .out_valid   (out_valid)
    );

    typedef struct {
        int due;
        int i;
        int q;
    } exp_t;

    exp_t pend[$];
    int   lut[256];
    int   m_cnt, m_phase, m_held, m_buf, cyc;
    bit   m_full;
    int   exp_i, exp_q;
    bit   exp_ov;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Signed sine/cosine from phase via the quadrant rules, then offset by 2048.
    task automatic calc_iq(input int ph, output int i, output int q);
        int quad, a, la, lna;
        quad = (ph >> 22) & 3;
        a    = (ph >> 14) & 255;
        la   = lut[a];
        lna  = lut[255 - a];
        case (quad)
            0:       begin q = 2048 + la;  i = 2048 + lna; end
            1:       begin q = 2048 + lna; i = 2048 - la;  end
            2:       begin q = 2048 - la;  i = 2048 - lna; end
            default: begin q = 2048 - lna; i = 2048 + la;  end
        endcase
    endtask

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_held = 0; m_buf = 0; m_full = 1'b0;
        pend.delete();
        exp_i = 2048; exp_q = 2048; exp_ov = 1'b0;
    endtask

    // One clock with the current inputs: advance the model, then compare all outputs.
    task automatic step();
        bit   tick, acc;
        exp_t e;
        tick = mod_en && (m_cnt == DIV - 1);
        acc  = audio_valid && mod_en && !m_full;
        @(posedge clk);
        #1;
        cyc++;
        if (!mod_en) begin
            m_cnt = 0;
            pend.delete();
            exp_i = 2048;
            exp_q = 2048;
        end else begin
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        if (tick) begin
            m_phase = (m_phase + FCW + m_held * (1 << SHIFT)) & 32'h00FF_FFFF;
            if (m_full) begin
                m_held = m_buf;
                m_full = 1'b0;
            end
            e.due = cyc + 3;
            calc_iq(m_phase, e.i, e.q);
            pend.push_back(e);
        end
        if (acc) begin
            m_buf  = int'(audio_sample) - 8192;
            m_full = 1'b1;
        end
        exp_ov = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e      = pend.pop_front();
            exp_ov = 1'b1;
            exp_i  = e.i;
            exp_q  = e.q;
        end
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("I_out", 32'(I_out), 32'(exp_i));
        check("Q_out", 32'(Q_out), 32'(exp_q));
        check("audio_ready", 32'(audio_ready), 32'(mod_en && !m_full));
        check("phase", 32'(dut.phase_acc_r), 32'(m_phase));
    endtask

    initial begin
        logic [23:0] p0;
        logic [23:0] d;
        int          it, p1, x;

        for (int k = 0; k < 256; k++)
            lut[k] = $rtoi(2047.0 * $sin(3.14159265358979 * (k + 0.5) / 512.0) + 0.5);

        cyc = 0;
        RSTn = 1'b0; mod_en = 1'b0; audio_valid = 1'b0; audio_sample = 14'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_I", 32'(I_out), 32'h800);
        check("rst_Q", 32'(Q_out), 32'h800);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(audio_ready), 32'd0);
        check("rst_phase", 32'(dut.phase_acc_r), 32'd0);
        RSTn = 1'b1;
        step();
        step();

        // Carrier only: held sample is 0, so every tick adds exactly the FCW.
        mod_en = 1'b1;
        repeat (DIV) step();
        check("phase_tick1", 32'(dut.phase_acc_r), 32'h400000);
        repeat (3) step();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_Q", 32'(Q_out), 32'hFFF);
        check("first_I", 32'(I_out), 32'h7FA);
        repeat (4) step();
        check("second_Q", 32'(Q_out), 32'h7FA);
        check("second_I", 32'(I_out), 32'h001);
        check("phase_tick2", 32'(dut.phase_acc_r), 32'h800000);
        step();
        check("phase_tick3", 32'(dut.phase_acc_r), 32'hC00000);

        // Full-scale positive sample.
        audio_sample = 14'h3FFF; audio_valid = 1'b1; step(); audio_valid = 1'b0;
        check("ready_fall", 32'(audio_ready), 32'd0);
        repeat (DIV - 1) step();
        check("ready_rise", 32'(audio_ready), 32'd1);
        check("phase_tick4", 32'(dut.phase_acc_r), 32'h000000);
        repeat (DIV) step();
        check("phase_3fff", 32'(dut.phase_acc_r), 32'h41FFF0);

        // Full-scale negative sample, then midpoint.
        audio_sample = 14'h0000; audio_valid = 1'b1; step(); audio_valid = 1'b0;
        repeat (DIV - 1) step();
        p0 = dut.phase_acc_r;
        repeat (DIV) step();
        d = dut.phase_acc_r - p0;
        check("step_0000", 32'(d), 32'h3E0000);
        audio_sample = 14'h2000; audio_valid = 1'b1; step(); audio_valid = 1'b0;
        repeat (DIV - 1) step();
        p0 = dut.phase_acc_r;
        repeat (DIV) step();
        d = dut.phase_acc_r - p0;
        check("step_2000", 32'(d), 32'h400000);

        // Write landing on the tick edge: that tick still uses the old held value.
        repeat (DIV - 1) step();
        p0 = dut.phase_acc_r;
        audio_sample = 14'h3FFF; audio_valid = 1'b1; step(); audio_valid = 1'b0;
        d = dut.phase_acc_r - p0;
        check("coincident_step", 32'(d), 32'h400000);
        check("coincident_ready", 32'(audio_ready), 32'd0);
        repeat (DIV) step();
        p0 = dut.phase_acc_r;
        repeat (DIV) step();
        d = dut.phase_acc_r - p0;
        check("coincident_late", 32'(d), 32'h41FFF0);

        // Steer the phase onto 24'hFFFFF0 with a zero held sample, then watch it wrap.
        it = 0;
        while (!(m_phase == 32'h00FF_FFF0 && m_held == 0) && it < 64) begin
            p1 = (m_phase + FCW + m_held * (1 << SHIFT)) & 32'h00FF_FFFF;
            x  = (32'h00FF_FFF0 - p1) & 32'h003F_FFFF;
            if (x >= 32'h0020_0000) x = x - 32'h0040_0000;
            x = x / 16;
            if (x > 8191) x = 8191;
            if (x < -8192) x = -8192;
            audio_sample = 14'(x + 8192); audio_valid = 1'b1; step(); audio_valid = 1'b0;
            repeat (DIV - 1) step();
            it++;
        end
        check("steer_reached", 32'(it < 64), 32'd1);
        repeat (DIV) step();
        check("phase_wrap", 32'(dut.phase_acc_r), 32'h3FFFF0);

        // Disable for 10 cycles with a tick still in the lookup pipeline.
        step();
        mod_en = 1'b0;
        p0 = dut.phase_acc_r;
        repeat (10) step();
        check("dis_phase", 32'(dut.phase_acc_r), 32'(p0));
        check("dis_I", 32'(I_out), 32'h800);
        mod_en = 1'b1;
        repeat (DIV - 1) step();
        check("reen_hold", 32'(dut.phase_acc_r), 32'(p0));
        step();
        d = dut.phase_acc_r - p0;
        check("reen_step", 32'(d), 32'h400000);

        // Asynchronous reset in the middle of a cycle.
        repeat (5) step();
        #2;
        RSTn = 1'b0; mod_en = 1'b0;
        #1;
        check("mid_rst_I", 32'(I_out), 32'h800);
        check("mid_rst_Q", 32'(Q_out), 32'h800);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(audio_ready), 32'd0);
        check("mid_rst_phase", 32'(dut.phase_acc_r), 32'd0);
        model_reset();
        #2;
        RSTn = 1'b1;
        step();

        // Random traffic with occasional enable drops.
        for (int n = 0; n < 400; n++) begin
            mod_en       = ($urandom_range(0, 24) != 0);
            audio_valid  = ($urandom_range(0, 2) == 0);
            audio_sample = 14'($urandom);
            step();
        end
        audio_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
